pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC controller for the term-project CPU.
- Each cycle it decides whether the 16-bit program counter register increments, holds, reloads the reset vector, or redirects to a branch, jump, call or return target.
- Drives the pc register's active-low load and data inputs, and takes its output back as `pc_q`.
- Holds a small return-address stack, squashes wrong-path fetches after a redirect, and provides halt/resume.

Parameters:
- RESET_VEC, 16'h0000, address loaded into the PC after reset.
- PC_STEP, 1, increment per sequential fetch (word addressed).
- RAS_DEPTH, 4, return-address stack entries (power of 2).
- FLUSH_CYCLES, 2, bubbles inserted after any redirect (>=1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset; synchronous, active-high.
- pc_q  in  16  current PC value from the pc register.
- stall  in  1  hold the PC this cycle.
- br_taken  in  1  conditional branch resolved taken.
- br_target  in  16  branch destination.
- jmp  in  1  unconditional jump.
- jmp_target  in  16  jump or call destination.
- call  in  1  subroutine call; destination is jmp_target.
- ret  in  1  subroutine return.
- halt  in  1  stop sequencing.
- resume  in  1  leave HALT.
- pc_d  out  16  next value presented to the pc register.
- pc_load_n  out  1  active-low load strobe to the pc register.
- fetch_valid  out  1  instruction fetched at pc_q is valid.
- flush  out  1  one-cycle pulse on the redirect cycle.
- halted  out  1  high in HALT.
- ras_ovf  out  1  sticky overflow flag.
- ras_unf  out  1  sticky underflow flag.

Behaviour:
- Registered state: fsm, flush counter, RAS storage, RAS pointer/count, sticky flags.
- pc_d, pc_load_n, fetch_valid and flush are combinational from registered state and inputs.
- States:
  - BOOT: pc_d=RESET_VEC, pc_load_n=0, fetch_valid=0. Always goes to RUN next cycle.
  - RUN: fetch_valid = ~stall.
  - FLUSH: fetch_valid=0; PC increments normally; redirect inputs (br_taken/jmp/call/ret) are ignored. Counter loads FLUSH_CYCLES on entry; returns to RUN when it reaches 0. halt still honoured.
  - HALT: pc_load_n=1, fetch_valid=0, halted=1. resume moves to RUN at the next edge with the PC unchanged.
- Reset: clr=1 at an edge forces BOOT, empties the RAS, clears ras_ovf/ras_unf and the counter. This applies mid-operation, including from HALT or FLUSH.
- Output values while clr=1: pc_load_n=0, pc_d=RESET_VEC, fetch_valid=0, flush=0, halted=0.
- RUN priority, highest first: halt > ret > call > jmp > br_taken > stall > increment.
  - halt: pc_load_n=1, go to HALT.
  - ret:
    - RAS non-empty: pc_d = top entry, pop.
    - RAS empty: set ras_unf, pc_load_n=1, go to HALT.
  - call: pc_d=jmp_target; push pc_q+PC_STEP.
  - jmp: pc_d=jmp_target.
  - br_taken: pc_d=br_target.
  - Any taken redirect: pc_load_n=0, flush=1 for that cycle, go to FLUSH. Redirects override stall.
  - stall (no redirect): pc_load_n=1.
  - increment: pc_d = pc_q+PC_STEP, pc_load_n=0. Wraps modulo 2^16 (16'hFFFF+1 = 16'h0000).
- RAS:
  - LIFO, count saturates at RAS_DEPTH.
  - Push when full: oldest entry overwritten (circular), ras_ovf set, count stays RAS_DEPTH.
  - Return address computed mod 2^16.
- halt during FLUSH: goes to HALT; the remaining flush count is discarded.
- Simultaneous halt and resume in HALT: stay halted.

Decomposition:
- Shared package cpu_pkg: 16-bit address width constant and the fsm state encoding (BOOT, RUN, FLUSH, HALT).
- One natural sub-module: ras_stack (push/pop/top/count, overflow wrap, underflow indication), instantiated once.
- Everything else lives inline in pc_sequencer.

Test Plan:
- Reset then run: clr=1 for 2 cycles, then 0 with pc model connected → BOOT loads 16'h0000; pc_q = 0,1,2,3 on following cycles; fetch_valid=1 from first RUN cycle.
- Stall: pc_q=5, stall high 3 cycles → pc_load_n=1, pc_q stays 5, fetch_valid=0; resumes 6,7.
- Branch/flush: at pc_q=10, br_taken=1, br_target=16'h0040 → flush=1 that cycle; pc_q=0x40,0x41,0x42; fetch_valid=0 for 2 cycles after; br_taken=1 at 0x40 ignored.
- Call/return: call at pc_q=0x20 to 0x100, then ret at 0x105 (after flush) → PC 0x100…, then 0x21; ret on empty RAS → ras_unf=1, halted=1, PC holds.
- RAS overflow: 5 nested calls from addresses A0..A4 → ras_ovf=1; 4 rets return A4+1, A3+1, A2+1, A1+1; 5th ret → underflow halt.
- Halt/resume and wrap: halt at 16'hFFFF → PC holds; resume → pc_q=16'h0000 next; clr asserted in HALT → BOOT, flags cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared address width and sequencer state encoding
package cpu_pkg;
  localparam int AW = 16;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack, oldest entry overwritten when full
module ras_stack import cpu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   cnt;
  assign empty = cnt == '0;
  assign full  = cnt == (PW+1)'(DEPTH);
  assign top   = mem[ptr - PW'(1)];
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= ptr + PW'(1);
      cnt      <= full ? cnt : cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with return stack, flush bubbles and halt
module pc_sequencer import cpu_pkg::*; #(
  parameter logic [AW-1:0] RESET_VEC    = 16'h0000,
  parameter logic [AW-1:0] PC_STEP      = 16'h0001,
  parameter int            RAS_DEPTH    = 4,
  parameter int            FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] pc_q,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_target,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic          resume,
  output logic [AW-1:0] pc_d,
  output logic          pc_load_n,
  output logic          fetch_valid,
  output logic          flush,
  output logic          halted,
  output logic          ras_ovf,
  output logic          ras_unf
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] inc, top;
  logic          push, pop, set_unf, empty, full;
  assign inc    = pc_q + PC_STEP;
  assign halted = state == HALT && !clr;
  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (top),
    .empty (empty),
    .full  (full)
  );
  always_comb begin
    nxt         = state;
    cnt_nxt     = cnt;
    pc_d        = inc;
    pc_load_n   = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    set_unf     = 1'b0;
    if (clr) begin
      pc_d = RESET_VEC;
      nxt  = BOOT;
    end else begin
      case (state)
        BOOT: begin
          pc_d = RESET_VEC;
          nxt  = RUN;
        end
        RUN: begin
          fetch_valid = ~stall;
          if (halt) begin
            pc_load_n = 1'b1;
            nxt       = HALT;
          end else if (ret && empty) begin
            set_unf   = 1'b1;
            pc_load_n = 1'b1;
            nxt       = HALT;
          end else if (ret || call || jmp || br_taken) begin
            pc_d    = ret ? top : (call || jmp) ? jmp_target : br_target;
            pop     = ret;
            push    = call && !ret;
            flush   = 1'b1;
            nxt     = FLUSH;
            cnt_nxt = CW'(FLUSH_CYCLES);
          end else begin
            pc_load_n = stall;
          end
        end
        FLUSH: begin
          if (halt) begin
            pc_load_n = 1'b1;
            nxt       = HALT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
            nxt     = cnt <= CW'(1) ? RUN : FLUSH;
          end
        end
        default: begin
          pc_load_n = 1'b1;
          nxt       = resume && !halt ? RUN : HALT;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= BOOT;
      cnt     <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      ras_ovf <= ras_ovf | (push & full);
      ras_unf <= ras_unf | set_unf;
    end
  end
endmodule
